multi_ch_mem_model: RTL and testbench

//  Parametrised behavioural memory model for the stream/DMA test benches. NUM_CH read requesters share
//  one round-robin arbitrated read port with a fixed-latency, channel-tagged response pipeline.
//  A byte-enabled write port lets benches preload or modify contents. Sits between DMA engines under

---
 rtl/mem_model_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/multi_ch_mem_model.sv | 149 ++++++++++++++
 tb/tb_multi_ch_mem_model.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_model_pkg.sv
// Shared constants and helpers for the multi-channel memory model.
package mem_model_pkg;

    localparam int BYTE_W = 8;

    // Index width that never collapses to zero, so single-entry selects stay legal.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner. Grants are suppressed in reset.
module rr_arbiter
    import mem_model_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N-1:0]              req,
    output logic [N-1:0]              grant,
    output logic [clog2_min1(N)-1:0]  grant_idx
);

    localparam int IDX_W = clog2_min1(N);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_next;
    logic             any_grant;
    int               cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = 0;
        ptr_next  = ptr;
        if (rst_n) begin
            for (int off = 0; off < N; off++) begin
                cand = (int'(ptr) + off) % N;
                if (!any_grant && req[IDX_W'(cand)]) begin
                    any_grant                = 1'b1;
                    grant[IDX_W'(cand)]      = 1'b1;
                    grant_idx                = IDX_W'(cand);
                end
            end
            ptr_next = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (any_grant) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/multi_ch_mem_model.sv
// Multi-channel behavioural memory: round-robin read port with a fixed-latency
// tagged response pipeline and a byte-enabled write port. Optional MEM_ERR_RESP_EN.
module multi_ch_mem_model
    import mem_model_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int DEPTH        = 256,
    parameter int NUM_CH       = 2,
    parameter int READ_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            rd_valid,
    input  logic [NUM_CH*ADDR_W-1:0]     rd_addr,
    output logic [NUM_CH-1:0]            rd_ready,
    output logic                         rd_resp_valid,
    output logic [clog2_min1(NUM_CH)-1:0] rd_resp_ch,
    output logic [DATA_W-1:0]            rd_resp_data,
`ifdef MEM_ERR_RESP_EN
    output logic                         rd_resp_err,
`endif
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [DATA_W/BYTE_W-1:0]     wr_be
);

    localparam int CH_W      = clog2_min1(NUM_CH);
    localparam int IDX_W     = clog2_min1(DEPTH);
    localparam int NUM_BYTES = DATA_W / BYTE_W;

    // Words are stored XORed with their own index, so the all-zero power-up
    // image reads back as mem[i] == i without any reset-time loading.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    function automatic logic [DATA_W-1:0] word_key(input logic [IDX_W-1:0] idx);
        return DATA_W'(idx);
    endfunction

    logic [CH_W-1:0]   grant_idx;
    logic              rd_fire;
    logic [ADDR_W-1:0] rd_addr_sel;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_word;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_key;
    logic              wr_ok;

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (rd_valid),
        .grant     (rd_ready),
        .grant_idx (grant_idx)
    );

    assign rd_fire     = |rd_ready;
    assign rd_addr_sel = rd_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    assign rd_idx      = IDX_W'(rd_addr_sel);
    assign wr_idx      = IDX_W'(wr_addr);
    assign wr_key      = word_key(wr_idx);

`ifdef MEM_ERR_RESP_EN
    localparam int CMP_W = ADDR_W + 32;

    logic rd_oob;
    logic wr_oob;

    assign rd_oob  = CMP_W'(rd_addr_sel) >= CMP_W'(DEPTH);
    assign wr_oob  = CMP_W'(wr_addr) >= CMP_W'(DEPTH);
    assign rd_word = rd_oob ? '0 : (mem[rd_idx] ^ word_key(rd_idx));
    assign wr_ok   = wr_en && !wr_oob;
`else
    logic unused_addr_hi;

    assign unused_addr_hi = ^{rd_addr_sel, wr_addr};
    assign rd_word        = mem[rd_idx] ^ word_key(rd_idx);
    assign wr_ok          = wr_en;
`endif

    // Combinational read above sees the pre-edge contents, giving read-first collisions.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][b*BYTE_W +: BYTE_W] <= wr_data[b*BYTE_W +: BYTE_W] ^ wr_key[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    logic              pipe_valid [READ_LATENCY];
    logic [CH_W-1:0]   pipe_ch    [READ_LATENCY];
    logic [DATA_W-1:0] pipe_data  [READ_LATENCY];
`ifdef MEM_ERR_RESP_EN
    logic              pipe_err   [READ_LATENCY];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
            end
        end else begin
            pipe_valid[0] <= rd_fire;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // Payload stages carry no reset; only the valid bits decide what is live.
    always_ff @(posedge clk) begin
        pipe_ch[0]   <= grant_idx;
        pipe_data[0] <= rd_word;
`ifdef MEM_ERR_RESP_EN
        pipe_err[0]  <= rd_oob;
`endif
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_ch[i]   <= pipe_ch[i-1];
            pipe_data[i] <= pipe_data[i-1];
`ifdef MEM_ERR_RESP_EN
            pipe_err[i]  <= pipe_err[i-1];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_resp_valid <= 1'b0;
            rd_resp_ch    <= '0;
            rd_resp_data  <= '0;
`ifdef MEM_ERR_RESP_EN
            rd_resp_err   <= 1'b0;
`endif
        end else begin
            rd_resp_valid <= pipe_valid[READ_LATENCY-1];
            if (pipe_valid[READ_LATENCY-1]) begin
                rd_resp_ch   <= pipe_ch[READ_LATENCY-1];
                rd_resp_data <= pipe_data[READ_LATENCY-1];
`ifdef MEM_ERR_RESP_EN
                rd_resp_err  <= pipe_err[READ_LATENCY-1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_multi_ch_mem_model.sv
// Directed, table-driven bench for multi_ch_mem_model (NUM_CH=2, READ_LATENCY=2).
// Honors MEM_ERR_RESP_EN for the error-response port and expectations.
module tb_multi_ch_mem_model;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rd_valid;
    logic [63:0] rd_addr;
    logic [1:0]  rd_ready;
    logic        rd_resp_valid;
    logic [0:0]  rd_resp_ch;
    logic [31:0] rd_resp_data;
    logic        rd_resp_err;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

`ifdef MEM_ERR_RESP_EN
    localparam bit          ERR_EN    = 1'b1;
    localparam logic [31:0] WRAP_DATA = 32'h0;
    localparam logic [31:0] OOB_WDATA = 32'd11;
`else
    localparam bit          ERR_EN    = 1'b0;
    localparam logic [31:0] WRAP_DATA = 32'd3;
    localparam logic [31:0] OOB_WDATA = 32'h0000DEAD;
    assign rd_resp_err = 1'b0;
`endif

    multi_ch_mem_model #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(256), .NUM_CH(2), .READ_LATENCY(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_valid      (rd_valid),
        .rd_addr       (rd_addr),
        .rd_ready      (rd_ready),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_ch    (rd_resp_ch),
        .rd_resp_data  (rd_resp_data),
`ifdef MEM_ERR_RESP_EN
        .rd_resp_err   (rd_resp_err),
`endif
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_be         (wr_be)
    );

    typedef struct {
        logic [1:0]  rv_in;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        we;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [1:0]  exp_ready;
        logic        exp_rv;
        logic        exp_ch;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] rv_in, input logic [31:0] a0, input logic [31:0] a1,
                                input logic we, input logic [31:0] wa, input logic [31:0] wd,
                                input logic [3:0] be, input logic [1:0] exp_ready, input logic exp_rv,
                                input logic exp_ch, input logic [31:0] exp_data, input logic exp_err);
        vec_t v;
        v.rv_in = rv_in; v.a0 = a0; v.a1 = a1; v.we = we; v.wa = wa; v.wd = wd; v.be = be;
        v.exp_ready = exp_ready; v.exp_rv = exp_rv; v.exp_ch = exp_ch; v.exp_data = exp_data;
        v.exp_err = exp_err;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rd_valid = v.rv_in;
        rd_addr  = {v.a1, v.a0};
        wr_en    = v.we;
        wr_addr  = v.wa;
        wr_data  = v.wd;
        wr_be    = v.be;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t idle;
        bit   resp_seen;
        int   grant_cycle;
        int   lat;

        idle = mk(2'b00, 0, 0, 0, 0, 0, 4'h0, 2'b00, 0, 0, 0, 0);
        applyStimulus(idle);
        rst_n    = 1'b0;
        rd_valid = 2'b11;
        repeat (3) stepCycle();
        checkOutput("reset_ready", 32'(rd_ready), 32'h0);
        checkOutput("reset_resp_valid", 32'(rd_resp_valid), 32'h0);
        checkOutput("reset_resp_ch", 32'(rd_resp_ch), 32'h0);
        checkOutput("reset_resp_data", rd_resp_data, 32'h0);
        checkOutput("reset_resp_err", 32'(rd_resp_err), 32'h0);

        rst_n = 1'b1;
        applyStimulus(idle);
        stepCycle();

        $display("[TB] latency: ch0 reads addr 5");
        rd_valid = 2'b01;
        rd_addr  = {32'd0, 32'd5};
        #1;
        checkOutput("lat_ready", 32'(rd_ready), 32'h1);
        grant_cycle = cycle;
        resp_seen   = 1'b0;
        lat         = 0;
        for (int i = 0; i < 10 && !resp_seen; i++) begin
            stepCycle();
            rd_valid = 2'b00;
            if (rd_resp_valid) begin
                resp_seen = 1'b1;
                lat       = cycle - grant_cycle;
            end
        end
        checkOutput("lat_resp_seen", 32'(resp_seen), 32'h1);
        if (resp_seen) begin
            checkOutput("lat_cycles", 32'(lat), 32'd3);
            checkOutput("lat_ch", 32'(rd_resp_ch), 32'h0);
            checkOutput("lat_data", rd_resp_data, 32'd5);
            stepCycle();
            checkOutput("lat_single_strobe", 32'(rd_resp_valid), 32'h0);
            checkOutput("lat_hold_data", rd_resp_data, 32'd5);
        end

        rst_n = 1'b0;
        stepCycle();
        rst_n = 1'b1;

        // RR fairness with both channels held valid
        vecs.push_back(mk(2'b11,   0, 100, 0, 0, 0, 4'h0, 2'b01, 0, 0, 32'd0,   0));
        vecs.push_back(mk(2'b11,   1, 100, 0, 0, 0, 4'h0, 2'b10, 0, 0, 32'd0,   0));
        vecs.push_back(mk(2'b11,   1, 101, 0, 0, 0, 4'h0, 2'b01, 0, 0, 32'd0,   0));
        vecs.push_back(mk(2'b11,   2, 101, 0, 0, 0, 4'h0, 2'b10, 1, 0, 32'd0,   0));
        vecs.push_back(mk(2'b11,   2, 102, 0, 0, 0, 4'h0, 2'b01, 1, 1, 32'd100, 0));
        vecs.push_back(mk(2'b11,   3, 102, 0, 0, 0, 4'h0, 2'b10, 1, 0, 32'd1,   0));
        vecs.push_back(mk(2'b11,   3, 103, 0, 0, 0, 4'h0, 2'b01, 1, 1, 32'd101, 0));
        vecs.push_back(mk(2'b10,   0, 103, 0, 0, 0, 4'h0, 2'b10, 1, 0, 32'd2,   0));
        vecs.push_back(mk(2'b00,   0,   0, 0, 0, 0, 4'h0, 2'b00, 1, 1, 32'd102, 0));
        vecs.push_back(mk(2'b00,   0,   0, 0, 0, 0, 4'h0, 2'b00, 1, 0, 32'd3,   0));
        vecs.push_back(mk(2'b00,   0,   0, 0, 0, 0, 4'h0, 2'b00, 1, 1, 32'd103, 0));
        vecs.push_back(mk(2'b00,   0,   0, 0, 0, 0, 4'h0, 2'b00, 0, 1, 32'd103, 0));
        // Byte-enable write then read back
        vecs.push_back(mk(2'b00,   0,   0, 1, 7, 32'hAABBCCDD, 4'b0101, 2'b00, 0, 1, 32'd103, 0));
        vecs.push_back(mk(2'b01,   7,   0, 0, 0, 0, 4'h0, 2'b01, 0, 1, 32'd103, 0));
        vecs.push_back(mk(2'b00,   0,   0, 0, 0, 0, 4'h0, 2'b00, 0, 1, 32'd103, 0));
        vecs.push_back(mk(2'b00,   0,   0, 0, 0, 0, 4'h0, 2'b00, 0, 1, 32'd103, 0));
        vecs.push_back(mk(2'b00,   0,   0, 0, 0, 0, 4'h0, 2'b00, 1, 0, 32'h00BB00DD, 0));
        // Read/write collision is read-first
        vecs.push_back(mk(2'b10,   0,   9, 1, 9, 32'h1234, 4'hF, 2'b10, 0, 0, 32'h00BB00DD, 0));
        vecs.push_back(mk(2'b10,   0,   9, 0, 0, 0, 4'h0, 2'b10, 0, 0, 32'h00BB00DD, 0));
        vecs.push_back(mk(2'b00,   0,   0, 0, 0, 0, 4'h0, 2'b00, 0, 0, 32'h00BB00DD, 0));
        vecs.push_back(mk(2'b00,   0,   0, 0, 0, 0, 4'h0, 2'b00, 1, 1, 32'd9,   0));
        vecs.push_back(mk(2'b00,   0,   0, 0, 0, 0, 4'h0, 2'b00, 1, 1, 32'h1234, 0));
        // Address beyond DEPTH, zero byte-enable write, out-of-range write
        vecs.push_back(mk(2'b01, 259,   0, 0, 0, 0, 4'h0, 2'b01, 0, 1, 32'h1234, 0));
        vecs.push_back(mk(2'b00,   0,   0, 1, 20, 32'hFFFFFFFF, 4'h0, 2'b00, 0, 1, 32'h1234, 0));
        vecs.push_back(mk(2'b10,   0,  20, 0, 0, 0, 4'h0, 2'b10, 0, 1, 32'h1234, 0));
        vecs.push_back(mk(2'b00,   0,   0, 1, 267, 32'h0000DEAD, 4'hF, 2'b00, 1, 0, WRAP_DATA, ERR_EN));
        vecs.push_back(mk(2'b01,  11,   0, 0, 0, 0, 4'h0, 2'b01, 0, 0, WRAP_DATA, 0));
        vecs.push_back(mk(2'b00,   0,   0, 0, 0, 0, 4'h0, 2'b00, 1, 1, 32'd20,  0));
        vecs.push_back(mk(2'b00,   0,   0, 0, 0, 0, 4'h0, 2'b00, 0, 1, 32'd20,  0));
        vecs.push_back(mk(2'b00,   0,   0, 0, 0, 0, 4'h0, 2'b00, 1, 0, OOB_WDATA, 0));
        vecs.push_back(mk(2'b00,   0,   0, 0, 0, 0, 4'h0, 2'b00, 0, 0, OOB_WDATA, 0));

        $display("[TB] applying %0d table vectors", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_ready", i), 32'(rd_ready), 32'(vecs[i].exp_ready));
            checkOutput($sformatf("vec%0d_resp_valid", i), 32'(rd_resp_valid), 32'(vecs[i].exp_rv));
            checkOutput($sformatf("vec%0d_resp_ch", i), 32'(rd_resp_ch), 32'(vecs[i].exp_ch));
            checkOutput($sformatf("vec%0d_resp_data", i), rd_resp_data, vecs[i].exp_data);
            if (vecs[i].exp_rv) begin
                checkOutput($sformatf("vec%0d_resp_err", i), 32'(rd_resp_err), 32'(vecs[i].exp_err));
            end
            stepCycle();
        end

        $display("[TB] reset with reads in flight");
        rd_valid = 2'b11;
        rd_addr  = {32'd41, 32'd40};
        #1;
        checkOutput("mid_grant0", 32'(rd_ready), 32'h2);
        stepCycle();
        checkOutput("mid_grant1", 32'(rd_ready), 32'h1);
        stepCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("mid_ready_in_reset", 32'(rd_ready), 32'h0);
        stepCycle();
        rst_n = 1'b1;
        applyStimulus(idle);
        checkOutput("mid_resp_valid_cleared", 32'(rd_resp_valid), 32'h0);
        checkOutput("mid_resp_ch_cleared", 32'(rd_resp_ch), 32'h0);
        checkOutput("mid_resp_data_cleared", rd_resp_data, 32'h0);
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            checkOutput($sformatf("mid_no_resp%0d", i), 32'(rd_resp_valid), 32'h0);
        end
        rd_valid = 2'b11;
        #1;
        checkOutput("mid_ptr_reset", 32'(rd_ready), 32'h1);
        stepCycle();
        applyStimulus(idle);
        repeat (4) stepCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
